// File: rtl/sram_array_ctrl.sv
//------------------------------------------------------------------------------
// sram_array_ctrl: sequences precharge / wordline / bitline phases for one
// SRAM row access.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sram_array_ctrl #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [ROWS-1:0]   wl,
  output logic [WIDTH-1:0]  bl,
  output logic [WIDTH-1:0]  blb,
  output logic              precharge,
  input  logic [WIDTH-1:0]  sense_in
);

  localparam logic [ADDR_W:0] ROWS_LIM = ROWS[ADDR_W:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    RECOVER = 3'd4,
    SENSE   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [WIDTH-1:0]   lat_wdata;
  logic               in_range;
  logic [ROWS-1:0]    row_sel;
  logic [ROWS-1:0]    wl_nx;
  logic [WIDTH-1:0]   bl_nx;
  logic [WIDTH-1:0]   blb_nx;
  logic               pre_nx;
  logic               vld_nx;
  logic               err_nx;
  logic               accept;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign in_range = ({1'b0, lat_addr} < ROWS_LIM);

  // An out-of-range address matches no row, so row_sel stays all-zero.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (lat_addr == r[ADDR_W-1:0]) row_sel[r] = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wl_nx    = '0;
    bl_nx    = '1;
    blb_nx   = '1;
    pre_nx   = 1'b0;
    vld_nx   = 1'b0;
    err_nx   = 1'b0;

    case (state)
      IDLE:    if (accept) state_nx = PRE;
      PRE:     state_nx = lat_we ? WRITE : READ;
      WRITE:   state_nx = RECOVER;
      READ:    state_nx = SENSE;
      RECOVER: state_nx = IDLE;
      SENSE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Array-side outputs are registered from the next state so each phase's
    // drive appears cleanly for exactly the cycle that state is held.
    case (state_nx)
      PRE:   pre_nx = 1'b1;
      WRITE: begin
        wl_nx  = row_sel;
        bl_nx  = lat_wdata;
        blb_nx = ~lat_wdata;
      end
      READ:  wl_nx = row_sel;
      RECOVER, SENSE: begin
        vld_nx = 1'b1;
        err_nx = ~in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wl        <= '0;
      bl        <= '1;
      blb       <= '1;
      precharge <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx == IDLE);
      wl        <= wl_nx;
      bl        <= bl_nx;
      blb       <= blb_nx;
      precharge <= pre_nx;
      rsp_valid <= vld_nx;
      rsp_err   <= err_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state == READ) rsp_rdata <= in_range ? sense_in : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
// Scoreboard bench: a 16-row and a 12-row controller share one request stream;
// a row-array model answers sense_in, a per-phase monitor checks every cycle.
`timescale 1ns/1ps

module tb_sram_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic        rdy16, rv16, err16, pre16;
  logic [7:0]  rd16, bl16, blb16, sense16;
  logic [15:0] wl16;
  logic        rdy12, rv12, err12, pre12;
  logic [7:0]  rd12, bl12, blb12, sense12;
  logic [11:0] wl12;

  always #5 clk = ~clk;

  sram_array_ctrl #(.ROWS(16), .ADDR_W(4), .WIDTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy16),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv16), .rsp_rdata(rd16), .rsp_err(err16), .wl(wl16),
    .bl(bl16), .blb(blb16), .precharge(pre16), .sense_in(sense16));

  sram_array_ctrl #(.ROWS(12), .ADDR_W(4), .WIDTH(8)) dut12 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy12),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv12), .rsp_rdata(rd12), .rsp_err(err12), .wl(wl12),
    .bl(bl12), .blb(blb12), .precharge(pre12), .sense_in(sense12));

  // Cell arrays: a row stores bl when selected with complementary bitlines.
  logic [7:0] cell16 [16];
  logic [7:0] cell12 [12];
  logic [7:0] junk;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    for (int r = 0; r < 16; r++)
      if (wl16[r] && (bl16 == ~blb16)) cell16[r] <= bl16;
    for (int r = 0; r < 12; r++)
      if (wl12[r] && (bl12 == ~blb12)) cell12[r] <= bl12;
  end

  always_comb begin
    sense16 = junk;
    for (int r = 0; r < 16; r++) if (wl16[r]) sense16 = cell16[r];
  end

  always_comb begin
    sense12 = junk;
    for (int r = 0; r < 12; r++) if (wl12[r]) sense12 = cell12[r];
  end

  typedef struct packed {
    int          acc;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    logic [15:0] wl;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mem [2][16];
  logic [7:0] last [2];
  int         tests = 0;
  int         fails = 0;
  int         cnt = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v,
                     input logic [63:0] mask);
    tests++;
    if ((act & mask) !== (exp_v & mask)) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (mask %h) at cycle %0d", name, act, exp_v, mask, cnt);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] w, input logic [7:0] b, input logic [7:0] bb,
                                     input logic pre, input logic rv, input logic er,
                                     input logic rdy, input logic [7:0] rd);
    return {20'h0, w, b, bb, pre, rv, er, rdy, rd};
  endfunction

  // Spec-level memory: writes store into in-range rows, reads return the stored
  // word (0 when out of range), and rsp_rdata holds the last read value.
  function automatic exp_t model(input int d, input logic we, input logic [3:0] a,
                                 input logic [7:0] wd, input int acc);
    exp_t e;
    int   rows;
    rows    = (d == 0) ? 16 : 12;
    e.acc   = acc;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.err   = (int'(a) >= rows);
    e.wl    = e.err ? 16'h0 : (16'h1 << a);
    if (we) begin
      if (!e.err) mem[d][a] = wd;
      e.rdata = last[d];
    end else begin
      e.rdata = e.err ? 8'h00 : mem[d][a];
      last[d] = e.rdata;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] wd,
                       input logic hold, output int acc);
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 20; i++) begin
      if (rdy16 && rdy12) begin
        acc = cnt + 1;
        q0.push_back(model(0, we, a, wd, acc));
        q1.push_back(model(1, we, a, wd, acc));
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 64'(rdy16), 64'h1, 64'h1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
  endtask

  localparam logic [63:0] M_ALL  = {20'h0, 44'hFFF_FFFF_FFFF};
  localparam logic [63:0] M_NORD = {20'h0, 44'hFFF_FFFF_FF00};
  localparam logic [63:0] M_IDLE = {20'h0, 44'hFFF_FFFF_FE00};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t        h;
      logic        busy;
      int          ph;
      logic [63:0] a;
      logic [15:0] w;
      logic [7:0]  b, bb;
      h    = '0;
      a    = (d == 0) ? pk(wl16, bl16, blb16, pre16, rv16, err16, rdy16, rd16)
                      : pk({4'h0, wl12}, bl12, blb12, pre12, rv12, err12, rdy12, rd12);
      w    = a[43:28];
      b    = a[27:20];
      bb   = a[19:12];
      busy = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (busy) h = (d == 0) ? q0[0] : q1[0];
      ph   = busy ? (cnt - h.acc) : -1;

      chk(d == 0 ? "invariants16" : "invariants12",
          {61'h0, ($countones(w) > 1), |(~b & ~bb), (!a[10] && a[9])}, 64'h0, 64'h7);

      if (!rst_n) begin
        chk("reset_state", a, pk(16'h0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      end else if (ph == 0) begin
        chk("precharge_phase", a, pk(16'h0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), M_NORD);
      end else if (ph == 1) begin
        chk(h.we ? "write_phase" : "read_phase", a,
            pk(h.wl, h.we ? h.wdata : 8'hFF, h.we ? ~h.wdata : 8'hFF,
               1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_NORD);
      end else if (ph == 2) begin
        chk(h.we ? "write_rsp" : "read_rsp", a,
            pk(16'h0, 8'hFF, 8'hFF, 1'b0, 1'b1, h.err, 1'b0, h.rdata), M_ALL);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end else if (ph > 2) begin
        chk("rsp_missing", 64'(ph), 64'd2, M_ALL);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end else begin
        chk("idle_state", a, pk(16'h0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_IDLE);
      end
    end
  end

  initial begin
    int a0, a1, a2, acc;
    logic [7:0] d5;
    last[0] = 8'h00;
    last[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {62'h0, rdy16, rdy12}, 64'h3, 64'h3);

    for (int r = 0; r < 16; r++) issue(1'b1, 4'(r), 8'($urandom), 1'b0, acc);

    issue(1'b1, 4'd3, 8'hA5, 1'b0, acc);
    issue(1'b0, 4'd3, 8'h00, 1'b0, acc);
    drain();

    issue(1'b0, 4'd0, 8'h00, 1'b1, a0);
    issue(1'b0, 4'd15, 8'h00, 1'b1, a1);
    issue(1'b0, 4'd7, 8'h00, 1'b0, a2);
    chk("b2b_spacing_0_15", 64'(a1 - a0), 64'd4, M_ALL);
    chk("b2b_spacing_15_7", 64'(a2 - a1), 64'd4, M_ALL);
    drain();

    issue(1'b0, 4'd13, 8'h00, 1'b0, acc);
    issue(1'b0, 4'd11, 8'h00, 1'b0, acc);
    drain();

    // Rewrite the stored word so the aborted write leaves the array consistent.
    d5 = mem[0][5];
    issue(1'b1, 4'd5, d5, 1'b0, acc);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_wl_drop", {36'h0, wl16, wl12}, 64'h0, {36'h0, 28'hFFF_FFFF});
    q0.delete();
    q1.delete();
    last[0] = 8'h00;
    last[1] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", {62'h0, rdy16, rdy12}, 64'h3, 64'h3);

    for (int n = 0; n < 1000; n++) begin
      issue(1'($urandom), 4'($urandom_range(15)), 8'($urandom), 1'($urandom), acc);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    chk("final_drain", 64'(q0.size() + q1.size()), 64'h0, M_ALL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_array_ctrl.md
SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 16, meaning the number of wordlines, i.e. cell rows.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the row address width; ADDR_W SHALL be at least clog2(ROWS).
REQ-003 The block SHALL have parameter WIDTH, default 8, meaning the number of cell columns per row.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req_valid, input, 1 bit: request present.
REQ-007 Port req_ready, output, 1 bit: the block accepts a request.
REQ-008 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W bits: the row address.
REQ-010 Port req_wdata, input, WIDTH bits: the write data.
REQ-011 Port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 Port rsp_rdata, output, WIDTH bits: the read data.
REQ-013 Port rsp_err, output, 1 bit: the address was out of range; qualified by rsp_valid.
REQ-014 Port wl, output, ROWS bits: the one-hot row select lines feeding the cells' select inputs.
REQ-015 Port bl, output, WIDTH bits: the per-column true bitline, i.e. the cell data_in[0].
REQ-016 Port blb, output, WIDTH bits: the per-column complement bitline, i.e. the cell data_in[1].
REQ-017 Port precharge, output, 1 bit: the bitline precharge phase indicator.
REQ-018 Port sense_in, input, WIDTH bits: the column-muxed cell data_out values of the selected row.

Function
REQ-019 The FSM SHALL have the states IDLE, PRE, WRITE, READ, RECOVER and SENSE, held in one state register.
REQ-020 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-021 On acceptance, the block SHALL latch req_we, req_addr and req_wdata into internal registers and go IDLE->PRE; the request inputs SHALL then be ignored until the block returns to IDLE.
REQ-022 PRE SHALL last exactly 1 cycle with precharge=1, wl=0, bl=all ones and blb=all ones; it SHALL then go to WRITE if the latched we=1, else to READ.
REQ-023 WRITE SHALL last exactly 1 cycle with wl one-hot at the latched address, bl=wdata, blb=~wdata and precharge=0; it SHALL then go to RECOVER.
REQ-024 READ SHALL last exactly 1 cycle with wl one-hot at the latched address, bl=blb=all ones and precharge=0; rsp_rdata SHALL capture sense_in on the edge leaving READ; it SHALL then go to SENSE.
REQ-025 RECOVER and SENSE SHALL each last 1 cycle with wl=0 and bl=blb=all ones, assert rsp_valid=1, and then return to IDLE.
REQ-026 Latency SHALL be: acceptance edge E -> rsp_valid high in the cycle after edge E+2, i.e. 3 edges; the next request SHALL be acceptable at edge E+4 at the earliest.
REQ-027 In IDLE, wl SHALL be 0, bl=blb=all ones, precharge=0 and rsp_valid=0.
REQ-028 bl and blb SHALL never both be 0 in any bit, and wl SHALL never have more than one bit set.
REQ-029 If the latched address is ≥ ROWS, no wl bit SHALL assert in WRITE or READ, the sequence timing SHALL be unchanged, rsp_err SHALL be 1 with rsp_valid, and a read SHALL return rsp_rdata=0.
REQ-030 rsp_rdata SHALL hold its last value across writes and idle cycles; rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-031 wl, bl, blb and precharge SHALL be driven from registers so that they are glitch-free.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=IDLE, wl=0, bl=blb=all ones, precharge=0, req_ready=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0, and SHALL clear the latched request registers.
REQ-033 Reset asserted mid-sequence SHALL drop wl to 0 asynchronously, with no completion pulse for the aborted request.
REQ-034 req_ready SHALL rise in the first cycle after the first rising edge following rst_n deassertion.

Verification
REQ-035 Write then read, ROWS=16, WIDTH=8: write addr 3 data 0xA5; verify wl=0x0008, bl=0xA5 and blb=0x5A in WRITE; read addr 3 with the sense_in model returning 0xA5 -> rsp_rdata=0xA5 and rsp_err=0, 3 edges after acceptance.
REQ-036 Back-to-back: hold req_valid=1 continuously for reads of addr 0, 15, 7 -> acceptances exactly 4 edges apart and rsp_valid pulses exactly 4 edges apart, each 1 cycle wide.
REQ-037 Out of range with ROWS=12, ADDR_W=4: read addr 13 -> wl stays 0 throughout, rsp_valid=1 with rsp_err=1 and rsp_rdata=0; then read addr 11 -> wl=0x800 and rsp_err=0.
REQ-038 Reset mid-write: assert rst_n=0 during WRITE at addr 5 -> wl=0 immediately without waiting for an edge, no rsp_valid, and req_ready=1 one cycle after release.
REQ-039 Precharge check: for every access, precharge=1 for exactly 1 cycle, immediately before the wl assertion, with bl=blb=0xFF.
REQ-040 Invariants, checked every cycle over 1000 random requests: popcount(wl) ≤ 1, (~bl & ~blb)=0, and req_ready=0 whenever state≠IDLE.
